pll_phase_sequencer: RTL and testbench

//  Next-generation PLL dynamic-phase controller. Tracks the current phase of each PLL counter.

---
 rtl/pll_phase_pkg.sv | 39 +++
 rtl/pll_scanclk_gen.sv | 46 ++++
 rtl/pll_phase_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_pll_phase_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_phase_pkg.sv
// Shared types and helpers for the PLL dynamic-phase sequencer.
// Holds the FSM state encoding, the counter-select codes and the shortest-path step planner.
package pll_phase_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARESET,
    ST_CLKSW,
    ST_CALC,
    ST_SETUP,
    ST_STEP,
    ST_FINISH
  } state_t;

  localparam logic [2:0] SEL_ALL = 3'b000;
  localparam logic [2:0] SEL_M   = 3'b001;
  localparam logic [2:0] SEL_C0  = 3'b010;

  localparam int unsigned SWITCH_CLKS = 8;

  typedef struct packed {
    logic        up;
    logic [31:0] n;
  } step_plan_t;

  // d is the forward distance (target - ref) mod wrap; a tie at wrap/2 goes up.
  function automatic step_plan_t plan_steps(input logic [31:0] d, input logic [31:0] wrap);
    step_plan_t p;
    if (d <= (wrap >> 1)) begin
      p.up = 1'b1;
      p.n  = d;
    end else begin
      p.up = 1'b0;
      p.n  = wrap - d;
    end
    return p;
  endfunction

endpackage

// File: rtl/pll_scanclk_gen.sv
// Scanclk divider: toggles scanclk every DIV clocks while enabled and counts half-periods.
// o_tick is high in the cycle whose closing edge performs the toggle.
module pll_scanclk_gen #(
  parameter int DIV = 16,
  parameter int HPW = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           i_en,
  input  logic           i_clr,
  output logic           o_scanclk,
  output logic           o_tick,
  output logic [HPW-1:0] o_hp
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0]  r_div_cnt;
  logic           r_scanclk;
  logic [HPW-1:0] r_hp;

  assign o_tick    = i_en && (r_div_cnt == CW'(DIV - 1));
  assign o_scanclk = r_scanclk;
  assign o_hp      = r_hp;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_div_cnt <= '0;
      r_scanclk <= 1'b0;
      r_hp      <= '0;
    end else if (i_clr) begin
      r_div_cnt <= '0;
      r_scanclk <= 1'b0;
      r_hp      <= '0;
    end else if (i_en) begin
      if (o_tick) begin
        r_div_cnt <= '0;
        r_scanclk <= ~r_scanclk;
        r_hp      <= r_hp + 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pll_phase_sequencer.sv
// PLL dynamic-phase sequencer: tracks counter phases and steps the PLL along the shortest path.
// Define PLL_CLKSWITCH_EN to enable the areset/clkswitch input-clock change before stepping.
module pll_phase_sequencer
  import pll_phase_pkg::*;
#(
  parameter int NCNT     = 5,
  parameter int PHW      = 6,
  parameter int DIV      = 16,
  parameter int STEPHOLD = 6,
  parameter int MINHP    = 8,
  parameter int TIMEOUT  = 108
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              update,
  input  logic [2:0]        sel,
  input  logic [PHW-1:0]    target,
  input  logic              clksrc,
  input  logic              phase_done,
  output logic              areset,
  output logic              clkswitch,
  output logic [2:0]        phasecounterselect,
  output logic              phaseupdown,
  output logic              phasestep,
  output logic              scanclk,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [NCNT*PHW-1:0] cur_phase,
  output state_t            o_dbg_state
);

  localparam int WRAP = 2 ** PHW;
  localparam int HPW  = $clog2(TIMEOUT + 2);

  state_t         r_state, w_next;
  logic [2:0]     r_sel;
  logic [PHW-1:0] r_target;
  logic           r_dir;
  logic [PHW-1:0] r_nrem;
  logic [PHW-1:0] r_phase [NCNT];
  logic           r_busy, r_done, r_err;
  logic [2:0]     r_pcs;
  logic           r_updown, r_phasestep;

  logic [2:0]     w_k;
  logic           w_sel_valid;
  logic [PHW-1:0] w_ref, w_d;
  step_plan_t     w_plan;
  logic           w_unused_plan_hi;
  logic           w_tick;
  logic [HPW-1:0] w_hp, w_hp_nxt;
  logic           w_step_ok, w_timeout;
  logic           w_need_sw, w_wait_last;

`ifdef PLL_CLKSWITCH_EN
  logic [2:0] r_wait;
  logic       r_cur_src;

  assign w_need_sw   = (clksrc != r_cur_src);
  assign w_wait_last = (r_wait == 3'(SWITCH_CLKS - 1));
  assign areset      = (r_state == ST_ARESET);
  assign clkswitch   = (r_state == ST_CLKSW);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wait    <= '0;
      r_cur_src <= 1'b0;
    end else if (r_state == ST_ARESET || r_state == ST_CLKSW) begin
      r_wait <= r_wait + 1'b1;
      if (r_state == ST_CLKSW && w_wait_last) r_cur_src <= ~r_cur_src;
    end else begin
      r_wait <= '0;
    end
  end
`else
  logic w_unused_clksrc;
  assign w_unused_clksrc = clksrc;
  assign w_need_sw       = 1'b0;
  assign w_wait_last     = 1'b0;
  assign areset          = 1'b0;
  assign clkswitch       = 1'b0;
`endif

  pll_scanclk_gen #(.DIV(DIV), .HPW(HPW)) u_scanclk (
    .clk       (clk),
    .rstn      (rstn),
    .i_en      (r_state == ST_STEP),
    .i_clr     (w_next != ST_STEP),
    .o_scanclk (scanclk),
    .o_tick    (w_tick),
    .o_hp      (w_hp)
  );

  always_comb begin
    w_k         = r_sel - SEL_C0;
    w_sel_valid = (r_sel == SEL_ALL) || ((r_sel >= SEL_C0) && (int'(w_k) < NCNT));
    w_ref       = r_phase[0];
    for (int i = 0; i < NCNT; i++) begin
      if (int'(w_k) == i) w_ref = r_phase[i];
    end
    w_d              = r_target - w_ref;
    w_plan           = plan_steps(32'(w_d), 32'(WRAP));
    w_unused_plan_hi = |w_plan.n[31:PHW];
    w_hp_nxt         = w_hp + 1'b1;
    w_step_ok        = w_tick && (w_hp_nxt >= HPW'(MINHP)) && phase_done;
    w_timeout        = w_tick && !w_step_ok && (w_hp_nxt > HPW'(TIMEOUT));
  end

  // update is a one-cycle request taken only in IDLE; busy is the not-ready flag, so
  // a request raised while busy is dropped rather than held.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (update) w_next = w_need_sw ? ST_ARESET : ST_CALC;
      ST_ARESET: if (w_wait_last) w_next = ST_CLKSW;
      ST_CLKSW:  if (w_wait_last) w_next = ST_CALC;
      ST_CALC:   w_next = (!w_sel_valid || w_d == '0) ? ST_FINISH : ST_SETUP;
      ST_SETUP:  w_next = ST_STEP;
      ST_STEP: begin
        if (w_step_ok)      w_next = (r_nrem == PHW'(1)) ? ST_FINISH : ST_SETUP;
        else if (w_timeout) w_next = ST_FINISH;
      end
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sel       <= '0;
      r_target    <= '0;
      r_dir       <= 1'b1;
      r_nrem      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_pcs       <= SEL_C0;
      r_updown    <= 1'b1;
      r_phasestep <= 1'b0;
      for (int i = 0; i < NCNT; i++) r_phase[i] <= '0;
    end else begin
      r_done <= (r_state == ST_FINISH);
      case (r_state)
        ST_IDLE: begin
          if (update) begin
            r_sel    <= sel;
            r_target <= target;
            r_busy   <= 1'b1;
            r_err    <= 1'b0;
          end
        end
        ST_CALC: begin
          if (!w_sel_valid) begin
            r_err <= 1'b1;
          end else begin
            r_dir  <= w_plan.up;
            r_nrem <= w_plan.n[PHW-1:0];
          end
        end
        ST_SETUP: begin
          r_pcs       <= r_sel;
          r_updown    <= r_dir;
          r_phasestep <= 1'b1;
        end
        ST_STEP: begin
          if (w_tick && w_hp_nxt == HPW'(STEPHOLD)) r_phasestep <= 1'b0;
          if (w_step_ok) begin
            r_phasestep <= 1'b0;
            r_nrem      <= r_nrem - 1'b1;
            for (int i = 0; i < NCNT; i++) begin
              if (r_sel == SEL_ALL || int'(w_k) == i)
                r_phase[i] <= r_dir ? r_phase[i] + 1'b1 : r_phase[i] - 1'b1;
            end
          end else if (w_timeout) begin
            r_phasestep <= 1'b0;
            r_err       <= 1'b1;
          end
        end
        ST_FINISH: r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    cur_phase = '0;
    for (int i = 0; i < NCNT; i++) cur_phase[i*PHW +: PHW] = r_phase[i];
  end

  assign phasecounterselect = r_pcs;
  assign phaseupdown        = r_updown;
  assign phasestep          = r_phasestep;
  assign busy               = r_busy;
  assign done               = r_done;
  assign err                = r_err;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_pll_phase_sequencer.sv
// Directed bench for pll_phase_sequencer (NCNT=5, PHW=6, DIV=16, STEPHOLD=6, MINHP=8, TIMEOUT=108).
// Expected latency of a request with n completed steps and no clock change: 3 + 129*n clocks.
module tb_pll_phase_sequencer;
  import pll_phase_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        update = 1'b0;
  logic [2:0]  sel = 3'b000;
  logic [5:0]  target = 6'd0;
  logic        clksrc = 1'b0;
  logic        phase_done = 1'b1;
  logic        areset, clkswitch, phaseupdown, phasestep, scanclk, busy, done, err;
  logic [2:0]  phasecounterselect;
  logic [29:0] cur_phase;
  state_t      dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  int          res_lat, res_steps, res_ar, res_cs, n_dones;
  logic        res_ud;
  logic [2:0]  res_pcs;

  pll_phase_sequencer #(
    .NCNT(5), .PHW(6), .DIV(16), .STEPHOLD(6), .MINHP(8), .TIMEOUT(108)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .update             (update),
    .sel                (sel),
    .target             (target),
    .clksrc             (clksrc),
    .phase_done         (phase_done),
    .areset             (areset),
    .clkswitch          (clkswitch),
    .phasecounterselect (phasecounterselect),
    .phaseupdown        (phaseupdown),
    .phasestep          (phasestep),
    .scanclk            (scanclk),
    .busy               (busy),
    .done               (done),
    .err                (err),
    .cur_phase          (cur_phase),
    .o_dbg_state        (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // checking
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] pk(input int p0, input int p1, input int p2, input int p3, input int p4);
    return {6'(p4), 6'(p3), 6'(p2), 6'(p1), 6'(p0)};
  endfunction

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_areset"},  areset, 1'b0);
    check_eq({tag, "_clksw"},   clkswitch, 1'b0);
    check_eq({tag, "_pcs"},     phasecounterselect, 3'b010);
    check_eq({tag, "_updown"},  phaseupdown, 1'b1);
    check_eq({tag, "_pstep"},   phasestep, 1'b0);
    check_eq({tag, "_scanclk"}, scanclk, 1'b0);
    check_eq({tag, "_busy"},    busy, 1'b0);
    check_eq({tag, "_done"},    done, 1'b0);
    check_eq({tag, "_err"},     err, 1'b0);
    check_eq({tag, "_phase"},   cur_phase, 30'd0);
  endtask

  // drivers
  task automatic do_reset();
    @(posedge clk); #1;
    rstn   = 1'b0;
    update = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic request(input logic [2:0] s, input logic [5:0] t, input int poke_at);
    logic prev_ps;
    logic got;
    @(posedge clk); #1;
    update = 1'b1;
    sel    = s;
    target = t;
    @(posedge clk); #1;
    update    = 1'b0;
    res_lat   = 1;
    res_steps = 0;
    res_ar    = 0;
    res_cs    = 0;
    prev_ps   = 1'b0;
    got       = 1'b0;
    check_eq("busy_set", busy, 1'b1);
    check_eq("err_clr", err, 1'b0);
    while (!got && res_lat < 6000) begin
      if (phasestep && !prev_ps) res_steps++;
      prev_ps = phasestep;
      if (phasestep) begin
        res_ud  = phaseupdown;
        res_pcs = phasecounterselect;
      end
      if (areset)    res_ar++;
      if (clkswitch) res_cs++;
      if (done) begin
        got = 1'b1;
      end else begin
        update = (res_lat == poke_at);
        if (update) begin
          sel    = 3'b011;
          target = 6'd20;
        end
        @(posedge clk); #1;
        res_lat++;
      end
    end
    update = 1'b0;
    check_eq("done_seen", got, 1'b1);
    check_eq("busy_clr", busy, 1'b0);
    @(posedge clk); #1;
    check_eq("done_1clk", done, 1'b0);
  endtask

  // scenarios
  initial begin
    repeat (3) @(posedge clk);
    #1 check_reset_values("rst");
    rstn = 1'b1;

    // C0: 0 -> 5, five up steps
    request(3'b010, 6'd5, -1);
    check_eq("t1_lat", res_lat, 648);
    check_eq("t1_steps", res_steps, 5);
    check_eq("t1_ud", res_ud, 1'b1);
    check_eq("t1_pcs", res_pcs, 3'b010);
    check_eq("t1_phase", cur_phase, pk(5, 0, 0, 0, 0));
    check_eq("t1_err", err, 1'b0);

    // C0: 5 -> 60, nine down steps through the wrap
    request(3'b010, 6'd60, -1);
    check_eq("t2_lat", res_lat, 1164);
    check_eq("t2_steps", res_steps, 9);
    check_eq("t2_ud", res_ud, 1'b0);
    check_eq("t2_phase", cur_phase, pk(60, 0, 0, 0, 0));

    // C1: 0 -> 7, C0 untouched
    request(3'b011, 6'd7, -1);
    check_eq("t3_lat", res_lat, 906);
    check_eq("t3_steps", res_steps, 7);
    check_eq("t3_pcs", res_pcs, 3'b011);
    check_eq("t3_phase", cur_phase, pk(60, 7, 0, 0, 0));

    // all counters: 0 -> 32 is a tie and goes up
    do_reset();
    request(3'b000, 6'd32, -1);
    check_eq("t4_lat", res_lat, 4131);
    check_eq("t4_steps", res_steps, 32);
    check_eq("t4_ud", res_ud, 1'b1);
    check_eq("t4_pcs", res_pcs, 3'b000);
    check_eq("t4_sel_out", phasecounterselect, 3'b000);
    check_eq("t4_phase", cur_phase, pk(32, 32, 32, 32, 32));

    // phase_done stuck low: first step abandoned after 109 half-periods
    phase_done = 1'b0;
    request(3'b010, 6'd3, -1);
    check_eq("t5_lat", res_lat, 1748);
    check_eq("t5_steps", res_steps, 1);
    check_eq("t5_err", err, 1'b1);
    check_eq("t5_scanclk", scanclk, 1'b0);
    check_eq("t5_pstep", phasestep, 1'b0);
    check_eq("t5_phase", cur_phase, pk(32, 32, 32, 32, 32));
    phase_done = 1'b1;

    // a second update raised mid-step is dropped
    request(3'b010, 6'd36, 50);
    check_eq("t6_lat", res_lat, 519);
    check_eq("t6_steps", res_steps, 4);
    check_eq("t6_phase", cur_phase, pk(36, 32, 32, 32, 32));
    n_dones = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (done || busy) n_dones++;
    end
    check_eq("t6_no_queue", n_dones, 0);

    // invalid selects: M counter and C5
    request(3'b001, 6'd9, -1);
    check_eq("t7_lat", res_lat, 3);
    check_eq("t7_steps", res_steps, 0);
    check_eq("t7_err", err, 1'b1);
    check_eq("t7_phase", cur_phase, pk(36, 32, 32, 32, 32));
    request(3'b111, 6'd9, -1);
    check_eq("t8_lat", res_lat, 3);
    check_eq("t8_err", err, 1'b1);

    // clock source request
    do_reset();
    clksrc = 1'b1;
    request(3'b010, 6'd2, -1);
`ifdef PLL_CLKSWITCH_EN
    check_eq("t9_lat", res_lat, 277);
    check_eq("t9_areset", res_ar, 8);
    check_eq("t9_clksw", res_cs, 8);
`else
    check_eq("t9_lat", res_lat, 261);
    check_eq("t9_areset", res_ar, 0);
    check_eq("t9_clksw", res_cs, 0);
`endif
    check_eq("t9_phase", cur_phase, pk(2, 0, 0, 0, 0));
    request(3'b010, 6'd3, -1);
    check_eq("t9b_lat", res_lat, 132);
    check_eq("t9b_areset", res_ar, 0);
    check_eq("t9b_phase", cur_phase, pk(3, 0, 0, 0, 0));

    // reset in the middle of a down step
    clksrc = 1'b0;
    @(posedge clk); #1;
    update = 1'b1;
    sel    = 3'b011;
    target = 6'd60;
    @(posedge clk); #1;
    update = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_eq("t10_pstep_pre", phasestep, 1'b1);
    check_eq("t10_ud_pre", phaseupdown, 1'b0);
    check_eq("t10_pcs_pre", phasecounterselect, 3'b011);
    rstn = 1'b0;
    #1 check_reset_values("t10_rst");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    n_dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done) n_dones++;
    end
    check_eq("t10_no_done", n_dones, 0);
    check_eq("t10_busy", busy, 1'b0);
    check_eq("t10_phase", cur_phase, 30'd0);

    // report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
